usb_wire_arbiter: RTL and testbench

- Shares the single USB TX wire path between three line-driving requesters: 0 = SOF/keep-alive generator, 1 = byte transmitter (bit-stuff/NRZI engine), 2 = reset/resume line-state driver.
- Grants exclusive ownership, forwards only the owner's wire symbols into the TX bit FIFO, and revokes ownership from an owner that holds the wire without writing.
- Sits between the SIE transmit engines and the TX bit FIFO/line driver.

---
 rtl/usb_wire_arbiter.sv | 128 ++++++++++++
 tb/tb_usb_wire_arbiter.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_wire_arbiter.sv
// usb_wire_arbiter: grants the shared USB TX wire to one of three requesters, forwards the owner's
// symbols to the TX bit FIFO and revokes an owner that holds the wire without writing.
module usb_wire_arbiter #(
  parameter int RR_MODE    = 1,
  parameter int HOLD_LIMIT = 1024,
  parameter int CNT_W      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_wire_req_0,
  output logic       o_wire_gnt_0,
  output logic       o_wire_rdy_0,
  input  logic [1:0] i_wire_data_0,
  input  logic       i_wire_ctrl_0,
  input  logic       i_wire_fs_0,
  input  logic       i_wire_wen_0,
  input  logic       i_wire_req_1,
  output logic       o_wire_gnt_1,
  output logic       o_wire_rdy_1,
  input  logic [1:0] i_wire_data_1,
  input  logic       i_wire_ctrl_1,
  input  logic       i_wire_fs_1,
  input  logic       i_wire_wen_1,
  input  logic       i_wire_req_2,
  output logic       o_wire_gnt_2,
  output logic       o_wire_rdy_2,
  input  logic [1:0] i_wire_data_2,
  input  logic       i_wire_ctrl_2,
  input  logic       i_wire_fs_2,
  input  logic       i_wire_wen_2,
  output logic [1:0] o_tx_bits,
  output logic       o_tx_ctrl,
  output logic       o_tx_fs,
  output logic       o_tx_wen,
  input  logic       i_tx_fifo_full,
  output logic [1:0] o_arb_owner,
  output logic       o_hold_timeout_err
);
  typedef enum logic [1:0] {IDLE, OWNED, RELEASE, LOCKOUT} state_t;
  state_t           r_state, w_state_nxt;
  logic [1:0]       r_owner, r_last, w_win, w_k;
  logic [CNT_W-1:0] r_wd;
  logic [3:0]       w_req, w_wen, w_ctrl, w_fs;
  logic [1:0]       w_data [4];
  logic             w_own_req, w_own_wen, w_timeout, w_release;
  logic [1:0]       r_tx_bits;
  logic             r_tx_ctrl, r_tx_fs, r_tx_wen, r_err;

  // index 3 is a permanently idle slot so "no owner" can be used as an index
  assign w_req  = {1'b0, i_wire_req_2, i_wire_req_1, i_wire_req_0};
  assign w_wen  = {1'b0, i_wire_wen_2, i_wire_wen_1, i_wire_wen_0};
  assign w_ctrl = {1'b0, i_wire_ctrl_2, i_wire_ctrl_1, i_wire_ctrl_0};
  assign w_fs   = {1'b0, i_wire_fs_2, i_wire_fs_1, i_wire_fs_0};
  assign w_data[0] = i_wire_data_0;
  assign w_data[1] = i_wire_data_1;
  assign w_data[2] = i_wire_data_2;
  assign w_data[3] = 2'b00;

  // scan candidates from lowest to highest precedence so the last hit is the winner
  always_comb begin
    w_win = 2'd3;
    w_k = 2'd0;
    for (int d = 3; d >= 1; d--) begin
      w_k = RR_MODE != 0 ? 2'((int'(r_last) + d) % 3) : 2'(d - 1);
      w_win = w_req[w_k] ? w_k : w_win;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_own_req = r_state == OWNED && w_req[r_owner];
    w_own_wen = w_own_req && w_wen[r_owner];
    w_release = r_state == OWNED && !w_own_req;
    w_timeout = w_own_req && !w_own_wen && r_wd == CNT_W'(HOLD_LIMIT - 1);
    case (r_state)
      IDLE:    w_state_nxt = w_win != 2'd3 ? OWNED : IDLE;
      OWNED:   w_state_nxt = w_release ? RELEASE : w_timeout ? LOCKOUT : OWNED;
      RELEASE: w_state_nxt = IDLE;
      LOCKOUT: w_state_nxt = w_req[r_owner] ? LOCKOUT : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // r_owner keeps the revoked index through LOCKOUT; the visible owner is gated by state
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_owner   <= 2'd3;
      r_last    <= 2'd2;
      r_wd      <= '0;
      r_tx_bits <= 2'b00;
      r_tx_ctrl <= 1'b0;
      r_tx_fs   <= 1'b0;
      r_tx_wen  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_tx_wen <= w_own_wen || (w_release && r_tx_ctrl);
      r_err    <= w_timeout;
      r_wd     <= (r_state != OWNED || w_own_wen) ? '0 :
                  r_wd == CNT_W'(HOLD_LIMIT) ? r_wd : r_wd + 1'b1;
      if (w_own_wen) begin
        r_tx_bits <= w_data[r_owner];
        r_tx_ctrl <= w_ctrl[r_owner];
        r_tx_fs   <= w_fs[r_owner];
      end else if (w_release) begin
        r_tx_ctrl <= 1'b0;
      end
      if (r_state == IDLE && w_win != 2'd3) begin
        r_owner <= w_win;
        r_last  <= w_win;
      end
    end
  end

  assign o_wire_gnt_0       = w_own_req && r_owner == 2'd0;
  assign o_wire_gnt_1       = w_own_req && r_owner == 2'd1;
  assign o_wire_gnt_2       = w_own_req && r_owner == 2'd2;
  assign o_wire_rdy_0       = o_wire_gnt_0 && !i_tx_fifo_full;
  assign o_wire_rdy_1       = o_wire_gnt_1 && !i_tx_fifo_full;
  assign o_wire_rdy_2       = o_wire_gnt_2 && !i_tx_fifo_full;
  assign o_tx_bits          = r_tx_bits;
  assign o_tx_ctrl          = r_tx_ctrl;
  assign o_tx_fs            = r_tx_fs;
  assign o_tx_wen           = r_tx_wen;
  assign o_arb_owner        = r_state == OWNED ? r_owner : 2'd3;
  assign o_hold_timeout_err = r_err;
endmodule

// File: tb/tb_usb_wire_arbiter.sv
// tb_usb_wire_arbiter: directed scenarios plus randomized traffic against a behavioural model,
// run on a fixed-priority instance (index 0) and a round-robin instance (index 1).
module tb_usb_wire_arbiter;
  localparam int HOLD = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0] req, wen, ctrl, fs;
  logic [1:0] data [3];
  logic full;
  logic [2:0] gnt [2];
  logic [2:0] rdy [2];
  logic [1:0] own [2];
  logic [1:0] bits [2];
  logic txwen [2];
  logic tctrl [2];
  logic tfs [2];
  logic err [2];
  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    usb_wire_arbiter #(.RR_MODE(g), .HOLD_LIMIT(HOLD), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst),
      .i_wire_req_0(req[0]), .o_wire_gnt_0(gnt[g][0]), .o_wire_rdy_0(rdy[g][0]),
      .i_wire_data_0(data[0]), .i_wire_ctrl_0(ctrl[0]), .i_wire_fs_0(fs[0]), .i_wire_wen_0(wen[0]),
      .i_wire_req_1(req[1]), .o_wire_gnt_1(gnt[g][1]), .o_wire_rdy_1(rdy[g][1]),
      .i_wire_data_1(data[1]), .i_wire_ctrl_1(ctrl[1]), .i_wire_fs_1(fs[1]), .i_wire_wen_1(wen[1]),
      .i_wire_req_2(req[2]), .o_wire_gnt_2(gnt[g][2]), .o_wire_rdy_2(rdy[g][2]),
      .i_wire_data_2(data[2]), .i_wire_ctrl_2(ctrl[2]), .i_wire_fs_2(fs[2]), .i_wire_wen_2(wen[2]),
      .o_tx_bits(bits[g]), .o_tx_ctrl(tctrl[g]), .o_tx_fs(tfs[g]), .o_tx_wen(txwen[g]),
      .i_tx_fifo_full(full), .o_arb_owner(own[g]), .o_hold_timeout_err(err[g])
    );
  end

  task automatic pc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    wen = '0;
    ctrl = '0;
    fs = '0;
    full = 1'b0;
    for (int k = 0; k < 3; k++) data[k] = 2'b00;
    pc();
    pc();
    rst = 1'b1;
    #1;
  endtask

  task automatic wait_gnt(input int m, output int n);
    n = 0;
    while (gnt[m] == 3'b000 && n < 12) begin
      pc();
      n++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b0;
    req = 3'b111;
    wen = 3'b111;
    ctrl = 3'b111;
    pc();
    pc();
    for (int m = 0; m < 2; m++) begin
      tests_run++;
      if ({gnt[m], rdy[m], own[m], txwen[m], bits[m], tctrl[m], tfs[m], err[m]} !== 14'b000_000_11_0_00_0_0_0) begin
        tests_failed++;
        $display("FAIL reset_state[%0d]: gnt=%b rdy=%b owner=%0d txwen=%b err=%b, expected 000 000 3 0 0",
                 m, gnt[m], rdy[m], own[m], txwen[m], err[m]);
      end
    end
    wen = 3'b000;
    rst = 1'b1;
    #1;
    tests_run++;
    if (gnt[1] !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_release_idle: gnt=%b, expected 000", gnt[1]);
    end
    pc();
    for (int m = 0; m < 2; m++) begin
      tests_run++;
      if (gnt[m] !== 3'b001 || own[m] !== 2'd0) begin
        tests_failed++;
        $display("FAIL reset_first_grant[%0d]: gnt=%b owner=%0d, expected 001 0", m, gnt[m], own[m]);
      end
    end
  endtask

  task automatic test_round_robin();
    int n, o, rel;
    int exp_o [4] = '{0, 1, 2, 0};
    do_reset();
    req = 3'b111;
    rel = 0;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(1, n);
      o = exp_o[i];
      tests_run++;
      if (n >= 12 || own[1] !== 2'(o)) begin
        tests_failed++;
        $display("FAIL rr_order[%0d]: owner=%0d waited=%0d, expected owner %0d", i, own[1], n, o);
      end
      if (i > 0) begin
        tests_run++;
        if (cyc - rel < 2) begin
          tests_failed++;
          $display("FAIL rr_gap[%0d]: grant %0d cycles after release, expected >= 2", i, cyc - rel);
        end
      end
      wen[o] = 1'b1;
      pc();
      wen[o] = 1'b0;
      req[o] = 1'b0;
      #1;
      rel = cyc;
      tests_run++;
      if (gnt[1][o] !== 1'b0) begin
        tests_failed++;
        $display("FAIL rr_drop[%0d]: gnt=%b, expected bit %0d clear", i, gnt[1], o);
      end
      pc();
      req[o] = 1'b1;
    end
  endtask

  task automatic test_fixed_priority();
    int n;
    do_reset();
    req = 3'b100;
    wait_gnt(0, n);
    tests_run++;
    if (own[0] !== 2'd2) begin
      tests_failed++;
      $display("FAIL fp_first: owner=%0d, expected 2", own[0]);
    end
    req = 3'b111;
    pc();
    pc();
    tests_run++;
    if (own[0] !== 2'd2 || gnt[0] !== 3'b100) begin
      tests_failed++;
      $display("FAIL fp_no_preempt: owner=%0d gnt=%b, expected 2 100", own[0], gnt[0]);
    end
    req = 3'b011;
    #1;
    wait_gnt(0, n);
    tests_run++;
    if (n >= 12 || own[0] !== 2'd0) begin
      tests_failed++;
      $display("FAIL fp_second: owner=%0d, expected 0", own[0]);
    end
    req = 3'b010;
    #1;
    wait_gnt(0, n);
    tests_run++;
    if (n >= 12 || own[0] !== 2'd1) begin
      tests_failed++;
      $display("FAIL fp_third: owner=%0d, expected 1", own[0]);
    end
  endtask

  task automatic test_forwarding();
    int n;
    do_reset();
    req = 3'b010;
    wait_gnt(1, n);
    tests_run++;
    if (own[1] !== 2'd1 || rdy[1] !== 3'b010) begin
      tests_failed++;
      $display("FAIL fwd_grant: owner=%0d rdy=%b, expected 1 010", own[1], rdy[1]);
    end
    wen = 3'b011;
    data[1] = 2'b01;
    ctrl[1] = 1'b1;
    fs[1] = 1'b1;
    data[0] = 2'b10;
    ctrl[0] = 1'b0;
    fs[0] = 1'b0;
    pc();
    wen = 3'b000;
    #1;
    tests_run++;
    if ({txwen[1], bits[1], tctrl[1], tfs[1]} !== 5'b1_01_1_1) begin
      tests_failed++;
      $display("FAIL fwd_symbol: wen=%b bits=%b ctrl=%b fs=%b, expected 1 01 1 1", txwen[1], bits[1], tctrl[1], tfs[1]);
    end
    wen = 3'b001;
    pc();
    wen = 3'b000;
    #1;
    tests_run++;
    if ({txwen[1], bits[1], tctrl[1], tfs[1]} !== 5'b0_01_1_1) begin
      tests_failed++;
      $display("FAIL fwd_nonowner: wen=%b bits=%b ctrl=%b fs=%b, expected 0 01 1 1", txwen[1], bits[1], tctrl[1], tfs[1]);
    end
    full = 1'b1;
    #1;
    tests_run++;
    if (rdy[1] !== 3'b000 || gnt[1] !== 3'b010) begin
      tests_failed++;
      $display("FAIL fwd_full: rdy=%b gnt=%b, expected 000 010", rdy[1], gnt[1]);
    end
    full = 1'b0;
    #1;
    tests_run++;
    if (rdy[1] !== 3'b010) begin
      tests_failed++;
      $display("FAIL fwd_not_full: rdy=%b, expected 010", rdy[1]);
    end
  endtask

  task automatic test_release_symbol();
    int n;
    do_reset();
    req = 3'b010;
    wait_gnt(1, n);
    wen = 3'b010;
    data[1] = 2'b10;
    ctrl[1] = 1'b1;
    fs[1] = 1'b0;
    pc();
    wen = 3'b000;
    req = 3'b000;
    #1;
    tests_run++;
    if (gnt[1] !== 3'b000 || rdy[1] !== 3'b000) begin
      tests_failed++;
      $display("FAIL rel_drop: gnt=%b rdy=%b, expected 000 000", gnt[1], rdy[1]);
    end
    pc();
    tests_run++;
    if ({txwen[1], tctrl[1], bits[1], own[1]} !== 6'b1_0_10_11) begin
      tests_failed++;
      $display("FAIL rel_symbol: wen=%b ctrl=%b bits=%b owner=%0d, expected 1 0 10 3", txwen[1], tctrl[1], bits[1], own[1]);
    end
    pc();
    tests_run++;
    if (txwen[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL rel_after: wen=%b, expected 0", txwen[1]);
    end
    req = 3'b010;
    #1;
    wait_gnt(1, n);
    wen = 3'b010;
    data[1] = 2'b11;
    ctrl[1] = 1'b0;
    pc();
    wen = 3'b000;
    req = 3'b000;
    pc();
    tests_run++;
    if (txwen[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL rel_no_symbol: wen=%b, expected 0", txwen[1]);
    end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    req = 3'b001;
    wait_gnt(1, n);
    n = 0;
    while (gnt[1][0] && n < 20) begin
      pc();
      n++;
    end
    tests_run++;
    if (n !== HOLD) begin
      tests_failed++;
      $display("FAIL tmo_cycles: grant held %0d cycles, expected %0d", n, HOLD);
    end
    tests_run++;
    if (err[1] !== 1'b1 || own[1] !== 2'd3) begin
      tests_failed++;
      $display("FAIL tmo_pulse: err=%b owner=%0d, expected 1 3", err[1], own[1]);
    end
    pc();
    tests_run++;
    if (err[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL tmo_pulse_width: err=%b, expected 0", err[1]);
    end
    req = 3'b011;
    pc();
    pc();
    pc();
    tests_run++;
    if (gnt[1] !== 3'b000) begin
      tests_failed++;
      $display("FAIL tmo_lockout: gnt=%b, expected 000", gnt[1]);
    end
    req = 3'b010;
    #1;
    wait_gnt(1, n);
    tests_run++;
    if (n >= 12 || own[1] !== 2'd1) begin
      tests_failed++;
      $display("FAIL tmo_unlock: owner=%0d, expected 1", own[1]);
    end
  endtask

  task automatic test_timeout_vs_drop();
    int n;
    do_reset();
    req = 3'b001;
    wait_gnt(1, n);
    repeat (HOLD - 1) pc();
    req = 3'b000;
    pc();
    tests_run++;
    if (err[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL tmo_drop_a: err=%b, expected 0", err[1]);
    end
    pc();
    tests_run++;
    if (err[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL tmo_drop_b: err=%b, expected 0", err[1]);
    end
  endtask

  task automatic test_random();
    int m_own [2], m_lock [2], m_last [2], m_idle [2];
    bit m_rel [2], m_wen [2], m_ctrl [2], m_fs [2], m_err [2];
    logic [1:0] m_bits [2];
    logic [2:0] eg;
    logic [13:0] got, expv;
    bit nw, ne;
    int o;
    do_reset();
    for (int m = 0; m < 2; m++) begin
      m_own[m] = -1;
      m_lock[m] = -1;
      m_last[m] = 2;
      m_idle[m] = 0;
      m_rel[m] = 0;
      m_wen[m] = 0;
      m_ctrl[m] = 0;
      m_fs[m] = 0;
      m_err[m] = 0;
      m_bits[m] = 2'b00;
    end
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(7) == 0) req[k] = ~req[k];
        wen[k] = $urandom_range(2) == 0;
        data[k] = 2'($urandom);
        ctrl[k] = 1'($urandom);
        fs[k] = 1'($urandom);
      end
      full = $urandom_range(3) == 0;
      #1;
      for (int m = 0; m < 2; m++) begin
        eg = 3'b000;
        if (m_own[m] >= 0 && req[m_own[m]]) eg[m_own[m]] = 1'b1;
        expv = {eg, full ? 3'b000 : eg, m_own[m] >= 0 ? 2'(m_own[m]) : 2'd3,
                m_wen[m], m_bits[m], m_ctrl[m], m_fs[m], m_err[m]};
        got = {gnt[m], rdy[m], own[m], txwen[m], bits[m], tctrl[m], tfs[m], err[m]};
        tests_run++;
        if (got !== expv) begin
          tests_failed++;
          $display("FAIL random[%0d] mode %0d: got %b, expected %b (gnt rdy owner wen bits ctrl fs err)", c, m, got, expv);
        end
        nw = 0;
        ne = 0;
        if (m_own[m] >= 0) begin
          o = m_own[m];
          if (!req[o]) begin
            nw = m_ctrl[m];
            m_ctrl[m] = 0;
            m_own[m] = -1;
            m_rel[m] = 1;
          end else if (wen[o]) begin
            nw = 1;
            m_bits[m] = data[o];
            m_ctrl[m] = ctrl[o];
            m_fs[m] = fs[o];
            m_idle[m] = 0;
          end else begin
            m_idle[m]++;
            if (m_idle[m] == HOLD) begin
              m_lock[m] = o;
              m_own[m] = -1;
              ne = 1;
            end
          end
        end else if (m_rel[m]) begin
          m_rel[m] = 0;
        end else if (m_lock[m] >= 0) begin
          if (!req[m_lock[m]]) m_lock[m] = -1;
        end else if (req != 3'b000) begin
          if (m == 0) o = req[0] ? 0 : req[1] ? 1 : 2;
          else begin
            o = (m_last[m] + 1) % 3;
            while (!req[o]) o = (o + 1) % 3;
          end
          m_own[m] = o;
          m_last[m] = o;
          m_idle[m] = 0;
        end
        m_wen[m] = nw;
        m_err[m] = ne;
      end
      pc();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_round_robin();
    test_fixed_priority();
    test_forwarding();
    test_release_symbol();
    test_timeout();
    test_timeout_vs_drop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
